address_sum_diff: RTL and testbench
===================================

ADDRESS_SUM_DIFF -- requirements
Module: address_sum_diff

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, the operand/result width in bits.
REQ-002 The block SHALL have parameter LEVEL, default 5, the number of pipeline stages (the latency in cycles).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port i_Aj, input, SIZE bits: first operand (Aj register).
REQ-006 The block SHALL have port i_Ak, input, SIZE bits: second operand (Ak register).
REQ-007 The block SHALL have port i_Instr, input, 7 bits: instruction opcode.
REQ-008 The block SHALL have port o_Ai, output, SIZE bits: registered result (Ai register).
REQ-009 Positional instantiation order SHALL be i_Aj, i_Ak, i_Instr, clk, o_Ai, rst.

Function
REQ-010 i_Instr == 7'o020 SHALL select addition: Ai = Aj + Ak mod 2^SIZE.
REQ-011 i_Instr == 7'o021 SHALL select subtraction: Ai = Aj + ~Ak + 1 mod 2^SIZE (two's complement).
REQ-012 Any other opcode SHALL produce Ai = 0.
REQ-013 Overflow, carry-out and borrow SHALL be discarded; results wrap silently, with no flag outputs.
REQ-014 i_Aj, i_Ak and i_Instr SHALL be sampled on every rising clk edge, giving one new operation per cycle with no stalls and no handshake.
REQ-015 An operation sampled at edge N SHALL appear on o_Ai after edge N+LEVEL and hold for exactly one cycle, unless replaced by the next result.
REQ-016 Opcode and operands SHALL travel together through the pipeline, so a mixed add/sub stream keeps its ordering and per-operation correctness.
REQ-017 The carry chain SHALL be split across the LEVEL stages; the segments for SIZE=32, LEVEL=5 are 7,7,6,6,6 bits, LSB first, with the inter-stage carry registered.
REQ-018 o_Ai SHALL be driven directly from a flop, with no combinational path from any input to o_Ai.

Reset
REQ-019 While rst is high at a rising edge, every pipeline register (operands, opcode, partial sums, carries) SHALL clear to 0.
REQ-020 o_Ai SHALL read 0 on the cycle after reset and for the next LEVEL cycles, until the first post-reset operation emerges.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight operations; none emerges later.
REQ-022 Reset SHALL take priority over sampling.

Configuration
REQ-023 With macro ADDRESS_SUM_DIFF_VALID_EN defined, the block SHALL add output o_Valid, 1 bit, asserted alongside o_Ai when the emerging operation had opcode 7'o020 or 7'o021, and 0 after reset.
REQ-024 Without ADDRESS_SUM_DIFF_VALID_EN, o_Valid and its pipeline bits SHALL be absent; o_Ai behaviour SHALL be identical in both builds.

Structure
REQ-025 A shared package address_sum_diff_pkg SHALL hold the opcode constants OP_ADD = 7'o020 and OP_SUB = 7'o021, the default width 32 and the default stage count 5.
REQ-026 The block SHALL use one sub-module, address_sum_diff_stage: a registered segment adder with carry-in and carry-out that passes the remaining operand bits and opcode through; it is instantiated LEVEL times.

Verification
REQ-027 Add: Instr=7'o020, Aj=3, Ak=4 -> o_Ai=7 exactly 5 cycles later.
REQ-028 Subtract: Instr=7'o021, Aj=5, Ak=7 -> o_Ai=32'hFFFFFFFE after 5 cycles; Aj=9, Ak=9 -> 0.
REQ-029 Wrap: add 32'hFFFFFFFF + 1 -> 0; sub 0 - 1 -> 32'hFFFFFFFF; add 32'h7FFFFFFF + 1 -> 32'h80000000.
REQ-030 Streaming: all Aj, Ak pairs in 0..62, one per cycle, alternating add/sub -> each result matches the reference model delayed 5 cycles, with no gaps.
REQ-031 Reset mid-stream: rst high for 1 cycle after 3 issued operations -> o_Ai = 0 for the next 5 cycles and none of the 3 results appears.
REQ-032 Illegal opcode: Instr=7'o022, Aj=10, Ak=20 -> o_Ai=0 after 5 cycles; with ADDRESS_SUM_DIFF_VALID_EN defined, o_Valid=0.

Source files
------------

// File: rtl/address_sum_diff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : address_sum_diff_pkg
//  Purpose  : Shared opcode constants, default geometry and segment helpers
//             for the pipelined address add/subtract unit.
//  Contents : OP_ADD, OP_SUB, DEFAULT_SIZE, DEFAULT_LEVEL,
//             seg_width(), seg_lsb()
//  Revision : 1.0  initial release
// ============================================================================
package address_sum_diff_pkg;

  localparam logic [6:0] OP_ADD        = 7'o020;
  localparam logic [6:0] OP_SUB        = 7'o021;
  localparam int         DEFAULT_SIZE  = 32;
  localparam int         DEFAULT_LEVEL = 5;

  // Segments are as even as possible. The SIZE % LEVEL leftover bits go
  // one each to the lowest segments, e.g. 32/5 -> 7,7,6,6,6 (LSB first).
  function automatic int seg_width(input int size, input int level, input int idx);
    return (size / level) + ((idx < (size % level)) ? 1 : 0);
  endfunction

  function automatic int seg_lsb(input int size, input int level, input int idx);
    int lsb;
    lsb = 0;
    for (int i = 0; i < idx; i++) begin
      lsb += seg_width(size, level, i);
    end
    return lsb;
  endfunction

endpackage : address_sum_diff_pkg
`default_nettype wire

// File: rtl/address_sum_diff_stage.sv
`default_nettype none
// ============================================================================
//  Module   : address_sum_diff_stage
//  Purpose  : One registered segment of the split carry chain. It adds bits
//             [LSB +: WIDTH] of Aj and Ak (Ak inverted for OP_SUB) plus the
//             carry-in. The segment result is merged into the partial
//             result. Operands and opcode pass through to the next stage.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             i_aj/i_ak/i_instr - operands and opcode of this operation
//             i_res             - partial result from the previous stage
//             i_cin             - carry into this segment
//             o_aj/o_ak/o_instr - registered pass-through
//             o_res             - registered partial result
//             o_cout            - registered carry out of this segment
//  Revision : 1.0  initial release
// ============================================================================
module address_sum_diff_stage
  import address_sum_diff_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int LSB   = 0,
  parameter int WIDTH = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] i_aj,
  input  logic [SIZE-1:0] i_ak,
  input  logic [6:0]      i_instr,
  input  logic [SIZE-1:0] i_res,
  input  logic            i_cin,
  output logic [SIZE-1:0] o_aj,
  output logic [SIZE-1:0] o_ak,
  output logic [6:0]      o_instr,
  output logic [SIZE-1:0] o_res,
  output logic            o_cout
);

  logic            w_is_sub;
  logic            w_legal;
  logic [WIDTH-1:0] w_b_seg;
  logic [WIDTH:0]   w_sum;

  logic [SIZE-1:0] aj_d, aj_q;
  logic [SIZE-1:0] ak_d, ak_q;
  logic [6:0]      instr_d, instr_q;
  logic [SIZE-1:0] res_d, res_q;
  logic            cout_d, cout_q;

  assign w_is_sub = (i_instr == OP_SUB);
  assign w_legal  = (i_instr == OP_ADD) || w_is_sub;
  // Subtraction is Aj + ~Ak + 1. The +1 enters as the carry-in of the
  // lowest segment, which the top supplies.
  assign w_b_seg  = w_is_sub ? ~i_ak[LSB +: WIDTH] : i_ak[LSB +: WIDTH];
  assign w_sum    = {1'b0, i_aj[LSB +: WIDTH]} + {1'b0, w_b_seg}
                  + {{WIDTH{1'b0}}, i_cin};

  always_comb begin
    aj_d    = i_aj;
    ak_d    = i_ak;
    instr_d = i_instr;
    res_d   = i_res;
    // Unknown opcodes force every segment to zero, so the final result is 0.
    res_d[LSB +: WIDTH] = w_legal ? w_sum[WIDTH-1:0] : {WIDTH{1'b0}};
    cout_d  = w_sum[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aj_q    <= '0;
      ak_q    <= '0;
      instr_q <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      aj_q    <= aj_d;
      ak_q    <= ak_d;
      instr_q <= instr_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign o_aj    = aj_q;
  assign o_ak    = ak_q;
  assign o_instr = instr_q;
  assign o_res   = res_q;
  assign o_cout  = cout_q;

endmodule : address_sum_diff_stage
`default_nettype wire

// File: rtl/address_sum_diff.sv
`default_nettype none
// ============================================================================
//  Module   : address_sum_diff
//  Purpose  : Pipelined address adder/subtractor. Ai = Aj + Ak (OP_ADD) or
//             Aj - Ak (OP_SUB) mod 2^SIZE. Any other opcode gives 0. One
//             operation is accepted per cycle. The result appears LEVEL
//             cycles after it is sampled.
//  Ports    : i_Aj, i_Ak - operands      i_Instr - 7-bit opcode
//             clk        - clock         rst     - sync active-high reset
//             o_Ai       - registered result
//             o_Valid    - (ADDRESS_SUM_DIFF_VALID_EN only) result came from
//                          a legal opcode
//  Config   : `define ADDRESS_SUM_DIFF_VALID_EN to add o_Valid.
//  Note     : requires 1 <= LEVEL <= SIZE.
//  Revision : 1.0  initial release
// ============================================================================
module address_sum_diff
  import address_sum_diff_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int LEVEL = DEFAULT_LEVEL
) (
  input  logic [SIZE-1:0] i_Aj,
  input  logic [SIZE-1:0] i_Ak,
  input  logic [6:0]      i_Instr,
  input  logic            clk,
  output logic [SIZE-1:0] o_Ai,
  input  logic            rst
`ifdef ADDRESS_SUM_DIFF_VALID_EN
  ,
  output logic            o_Valid
`endif
);

  // Input rank: operands and opcode are captured together. Stage k then
  // adds segment k, one edge later per stage. The result is therefore
  // visible LEVEL edges after sampling.
  logic [SIZE-1:0] aj_d, aj_q;
  logic [SIZE-1:0] ak_d, ak_q;
  logic [6:0]      instr_d, instr_q;

  always_comb begin
    aj_d    = i_Aj;
    ak_d    = i_Ak;
    instr_d = i_Instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aj_q    <= '0;
      ak_q    <= '0;
      instr_q <= '0;
    end else begin
      aj_q    <= aj_d;
      ak_q    <= ak_d;
      instr_q <= instr_d;
    end
  end

  // Chain element k feeds stage k. Element LEVEL is the last stage's output.
  logic [SIZE-1:0] w_aj    [0:LEVEL];
  logic [SIZE-1:0] w_ak    [0:LEVEL];
  logic [6:0]      w_instr [0:LEVEL];
  logic [SIZE-1:0] w_res   [0:LEVEL];
  logic            w_carry [0:LEVEL];

  assign w_aj[0]    = aj_q;
  assign w_ak[0]    = ak_q;
  assign w_instr[0] = instr_q;
  assign w_res[0]   = '0;
  // The lowest segment's carry-in supplies the +1 of two's complement.
  assign w_carry[0] = (instr_q == OP_SUB);

  for (genvar k = 0; k < LEVEL; k++) begin : g_stage
    localparam int SEG_LSB   = seg_lsb(SIZE, LEVEL, k);
    localparam int SEG_WIDTH = seg_width(SIZE, LEVEL, k);

    address_sum_diff_stage #(
      .SIZE  (SIZE),
      .LSB   (SEG_LSB),
      .WIDTH (SEG_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_aj    (w_aj[k]),
      .i_ak    (w_ak[k]),
      .i_instr (w_instr[k]),
      .i_res   (w_res[k]),
      .i_cin   (w_carry[k]),
      .o_aj    (w_aj[k+1]),
      .o_ak    (w_ak[k+1]),
      .o_instr (w_instr[k+1]),
      .o_res   (w_res[k+1]),
      .o_cout  (w_carry[k+1])
    );
  end

  // The final carry is discarded. Operands leaving the last stage have no
  // consumer.
  logic [2*SIZE+7:0] w_tail_unused;
  assign w_tail_unused = {w_aj[LEVEL], w_ak[LEVEL], w_instr[LEVEL], w_carry[LEVEL]};

  assign o_Ai = w_res[LEVEL];

`ifdef ADDRESS_SUM_DIFF_VALID_EN
  // Legality is decided at the input. Only the single bit travels the
  // pipeline, so o_Valid comes straight from a flop.
  logic [LEVEL:0] valid_d, valid_q;

  always_comb begin
    valid_d = {valid_q[LEVEL-1:0], (i_Instr == OP_ADD) || (i_Instr == OP_SUB)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign o_Valid = valid_q[LEVEL];
`endif

endmodule : address_sum_diff
`default_nettype wire

// File: tb/tb_address_sum_diff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_address_sum_diff
//  Purpose  : Self-checking bench for address_sum_diff (SIZE=32, LEVEL=5).
//             The reference is a plain-arithmetic result function followed
//             by a LEVEL+1 deep delay queue. Reset zero-fills the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_address_sum_diff;

  localparam int         SIZE   = 32;
  localparam int         LEVEL  = 5;
  localparam logic [6:0] ADD    = 7'o020;
  localparam logic [6:0] SUB    = 7'o021;
  localparam logic [6:0] IDLE   = 7'o000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] i_Aj = '0;
  logic [SIZE-1:0] i_Ak = '0;
  logic [6:0]      i_Instr = '0;
  logic [SIZE-1:0] o_Ai;
`ifdef ADDRESS_SUM_DIFF_VALID_EN
  logic            o_Valid;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [SIZE-1:0] exp_res [$];
  logic            exp_vld [$];

  always #5 clk = ~clk;

  address_sum_diff #(.SIZE(SIZE), .LEVEL(LEVEL)) dut (
    .i_Aj    (i_Aj),
    .i_Ak    (i_Ak),
    .i_Instr (i_Instr),
    .clk     (clk),
    .o_Ai    (o_Ai),
    .rst     (rst)
`ifdef ADDRESS_SUM_DIFF_VALID_EN
    ,
    .o_Valid (o_Valid)
`endif
  );

  task automatic check_eq(input string tag, input logic [SIZE-1:0] got,
                          input logic [SIZE-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SIZE-1:0] ref_result(input logic [SIZE-1:0] a,
                                                 input logic [SIZE-1:0] b,
                                                 input logic [6:0] op);
    if (op == ADD) return a + b;
    if (op == SUB) return a - b;
    return '0;
  endfunction

  // Apply one operation for one edge, update the model, check o_Ai.
  task automatic step(input logic r, input logic [SIZE-1:0] a,
                      input logic [SIZE-1:0] b, input logic [6:0] op);
    rst = r; i_Aj = a; i_Ak = b; i_Instr = op;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i <= LEVEL; i++) begin
        exp_res[i] = '0;
        exp_vld[i] = 1'b0;
      end
    end else begin
      exp_res.push_front(ref_result(a, b, op));
      exp_vld.push_front((op == ADD) || (op == SUB));
      void'(exp_res.pop_back());
      void'(exp_vld.pop_back());
    end
    #1;
    check_eq("o_Ai", o_Ai, exp_res[LEVEL]);
`ifdef ADDRESS_SUM_DIFF_VALID_EN
    check_eq("o_Valid", {{(SIZE-1){1'b0}}, o_Valid}, {{(SIZE-1){1'b0}}, exp_vld[LEVEL]});
`endif
  endtask

  // Issue one op, idle LEVEL cycles, then compare against a fixed answer.
  task automatic directed(input string tag, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] b, input logic [6:0] op,
                          input logic [SIZE-1:0] want, input logic want_vld);
    step(1'b0, a, b, op);
    for (int i = 0; i < LEVEL; i++) step(1'b0, '0, '0, IDLE);
    check_eq(tag, o_Ai, want);
`ifdef ADDRESS_SUM_DIFF_VALID_EN
    check_eq({tag, "_vld"}, {{(SIZE-1){1'b0}}, o_Valid}, {{(SIZE-1){1'b0}}, want_vld});
`endif
  endtask

  initial begin
    for (int i = 0; i <= LEVEL; i++) begin
      exp_res.push_back('0);
      exp_vld.push_back(1'b0);
    end

    // Reset, then the output holds 0 until the first real op emerges.
    step(1'b1, '0, '0, IDLE);
    step(1'b1, '0, '0, IDLE);
    check_eq("reset_state", o_Ai, '0);
    for (int i = 0; i < LEVEL; i++) begin
      step(1'b0, 32'h1234_5678, 32'h1111_1111, (i == 0) ? ADD : IDLE);
      check_eq("post_reset_zero", o_Ai, '0);
    end
    step(1'b0, '0, '0, IDLE);  // the ADD issued above emerges here

    directed("add_3_4",      32'd3,          32'd4, ADD, 32'd7,          1'b1);
    directed("sub_5_7",      32'd5,          32'd7, SUB, 32'hFFFF_FFFE,  1'b1);
    directed("sub_9_9",      32'd9,          32'd9, SUB, 32'd0,          1'b1);
    directed("wrap_add_max", 32'hFFFF_FFFF,  32'd1, ADD, 32'd0,          1'b1);
    directed("wrap_sub_0_1", 32'd0,          32'd1, SUB, 32'hFFFF_FFFF,  1'b1);
    directed("add_7f_1",     32'h7FFF_FFFF,  32'd1, ADD, 32'h8000_0000,  1'b1);
    directed("illegal_022",  32'd10,         32'd20, 7'o022, 32'd0,      1'b0);

    // Every pair in 0..62, back to back, alternating add/sub.
    begin
      int n;
      n = 0;
      for (int a = 0; a < 63; a++) begin
        for (int b = 0; b < 63; b++) begin
          step(1'b0, SIZE'(a), SIZE'(b), n[0] ? SUB : ADD);
          n++;
        end
      end
    end
    for (int i = 0; i < LEVEL; i++) step(1'b0, '0, '0, IDLE);

    // Mid-stream reset: three ops in flight must never emerge.
    step(1'b0, 32'd100, 32'd200, ADD);
    step(1'b0, 32'd300, 32'd1,   SUB);
    step(1'b0, 32'hDEAD, 32'hBEEF, ADD);
    step(1'b1, 32'd5, 32'd5, ADD);
    check_eq("rst_flush", o_Ai, '0);
    for (int i = 0; i < LEVEL; i++) begin
      step(1'b0, '0, '0, IDLE);
      check_eq("rst_flush", o_Ai, '0);
    end

    // Random ops with random carry patterns, occasional illegal opcodes and
    // resets.
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      int sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? ADD : (sel < 8) ? SUB : 7'($urandom);
      step(($urandom_range(0, 49) == 0), SIZE'($urandom), SIZE'($urandom), op);
    end
    for (int i = 0; i < LEVEL; i++) step(1'b0, '0, '0, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_address_sum_diff
`default_nettype wire
